rc4_encrypt_core: RTL and testbench

//  Self-contained RC4 encryptor: the encode-side counterpart of the decrypt path.
//  - On start, runs S-box init, KSA scramble and PRGA against the shared 256x8 S RAM.
//  - Reads plaintext bytes from a ROM and writes ciphertext bytes to a RAM.
//  - Its output is the encrypted-message image that the cracker later decrypts.

---
 rtl/rc4_encrypt_core.sv | 238 +++++++++++++++++++++++
 tb/tb_rc4_encrypt_core.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_encrypt_core.sv
// RC4 encryptor: S-box init, KSA and PRGA against an external 256x8 S RAM, plaintext ROM in, ciphertext RAM out.
// Optional RC4_DROP_EN: discard DROP_N keystream bytes before encrypting.
module rc4_encrypt_core #(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned KEY_LEN = 3,
  parameter int unsigned DROP_N  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_LEN-1:0]   secret_key,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  input  logic [7:0]             s_q,
  output logic [7:0]             pt_address,
  input  logic [7:0]             pt_q,
  output logic [7:0]             ct_address,
  output logic [7:0]             ct_data,
  output logic                   ct_wren
);

  localparam int unsigned KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  if (MSG_LEN < 1 || MSG_LEN > 256 || KEY_LEN < 1 || DROP_N > 65535) begin : g_bad_param
    $error("rc4_encrypt_core: parameter out of range");
  end

  typedef enum logic [4:0] {
    IDLE, INIT,
    K_RD_I, K_WT_I, K_RD_J, K_WT_J, K_WR_I, K_WR_J,
    P_RD_I, P_WT_I, P_RD_J, P_WT_J, P_WR_I, P_WR_J,
    P_RD_T, P_WT_T, P_WR_CT, DONE
  } state_t;

  state_t               state, state_nx;
  logic [7:0]           i, i_nx, j, j_nx, k, k_nx, si, si_nx, sj, sj_nx;
  logic [KW-1:0]        km, km_nx;
  logic [8*KEY_LEN-1:0] key_r, key_nx;
  logic [7:0]           key_byte;
  logic                 busy_nx, done_nx, s_wren_nx, ct_wren_nx;
  logic [7:0]           s_address_nx, s_data_nx, pt_address_nx, ct_address_nx, ct_data_nx;

`ifdef RC4_DROP_EN
  localparam int unsigned DW = (DROP_N > 0) ? $clog2(DROP_N + 1) : 1;
  logic [DW-1:0] dcnt, dcnt_nx;
`endif

  always_comb begin
    key_byte = '0;
    for (int unsigned n = 0; n < KEY_LEN; n++)
      if (km == KW'(n)) key_byte = key_r[8*(KEY_LEN-1-n) +: 8];
  end

  // All outputs are registered: each state computes the values presented during the next cycle.
  always_comb begin
    state_nx      = state;
    i_nx          = i;
    j_nx          = j;
    k_nx          = k;
    si_nx         = si;
    sj_nx         = sj;
    km_nx         = km;
    key_nx        = key_r;
    busy_nx       = busy;
    done_nx       = 1'b0;
    s_wren_nx     = 1'b0;
    ct_wren_nx    = 1'b0;
    s_address_nx  = s_address;
    s_data_nx     = s_data;
    pt_address_nx = pt_address;
    ct_address_nx = ct_address;
    ct_data_nx    = ct_data;
`ifdef RC4_DROP_EN
    dcnt_nx       = dcnt;
`endif
    case (state)
      IDLE: if (start) begin
        key_nx   = secret_key;
        busy_nx  = 1'b1;
        i_nx     = '0;
        j_nx     = '0;
        k_nx     = '0;
        km_nx    = '0;
`ifdef RC4_DROP_EN
        dcnt_nx  = '0;
`endif
        state_nx = INIT;
      end
      INIT: begin
        s_address_nx = i;
        s_data_nx    = i;
        s_wren_nx    = 1'b1;
        i_nx         = i + 8'd1;
        if (i == 8'hFF) state_nx = K_RD_I;
      end
      K_RD_I: begin
        s_address_nx = i;
        state_nx     = K_WT_I;
      end
      K_WT_I: state_nx = K_RD_J;
      K_RD_J: begin
        si_nx        = s_q;
        j_nx         = j + s_q + key_byte;
        s_address_nx = j + s_q + key_byte;
        state_nx     = K_WT_J;
      end
      K_WT_J: state_nx = K_WR_I;
      K_WR_I: begin
        sj_nx        = s_q;
        s_address_nx = i;
        s_data_nx    = s_q;
        s_wren_nx    = 1'b1;
        state_nx     = K_WR_J;
      end
      K_WR_J: begin
        s_address_nx = j;
        s_data_nx    = si;
        s_wren_nx    = 1'b1;
        km_nx        = (km == KW'(KEY_LEN - 1)) ? '0 : km + KW'(1);
        i_nx         = i + 8'd1;
        if (i == 8'hFF) begin
          j_nx     = '0;
          state_nx = P_RD_I;
        end else begin
          state_nx = K_RD_I;
        end
      end
      P_RD_I: begin
        i_nx         = i + 8'd1;
        s_address_nx = i + 8'd1;
        state_nx     = P_WT_I;
      end
      P_WT_I: state_nx = P_RD_J;
      P_RD_J: begin
        si_nx        = s_q;
        j_nx         = j + s_q;
        s_address_nx = j + s_q;
        state_nx     = P_WT_J;
      end
      P_WT_J: state_nx = P_WR_I;
      P_WR_I: begin
        sj_nx        = s_q;
        s_address_nx = i;
        s_data_nx    = s_q;
        s_wren_nx    = 1'b1;
        state_nx     = P_WR_J;
      end
      P_WR_J: begin
        s_address_nx = j;
        s_data_nx    = si;
        s_wren_nx    = 1'b1;
`ifdef RC4_DROP_EN
        if (dcnt != DW'(DROP_N)) begin
          dcnt_nx  = dcnt + DW'(1);
          state_nx = P_RD_I;
        end else begin
          state_nx = P_RD_T;
        end
`else
        state_nx     = P_RD_T;
`endif
      end
      P_RD_T: begin
        s_address_nx  = si + sj;
        pt_address_nx = k;
        state_nx      = P_WT_T;
      end
      P_WT_T: state_nx = P_WR_CT;
      P_WR_CT: begin
        ct_address_nx = k;
        ct_data_nx    = s_q ^ pt_q;
        ct_wren_nx    = 1'b1;
        if (k == 8'(MSG_LEN - 1)) begin
          state_nx = DONE;
        end else begin
          k_nx     = k + 8'd1;
          state_nx = P_RD_I;
        end
      end
      DONE: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      si         <= '0;
      sj         <= '0;
      km         <= '0;
      key_r      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      s_address  <= '0;
      s_data     <= '0;
      s_wren     <= 1'b0;
      pt_address <= '0;
      ct_address <= '0;
      ct_data    <= '0;
      ct_wren    <= 1'b0;
`ifdef RC4_DROP_EN
      dcnt       <= '0;
`endif
    end else begin
      state      <= state_nx;
      i          <= i_nx;
      j          <= j_nx;
      k          <= k_nx;
      si         <= si_nx;
      sj         <= sj_nx;
      km         <= km_nx;
      key_r      <= key_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      s_address  <= s_address_nx;
      s_data     <= s_data_nx;
      s_wren     <= s_wren_nx;
      pt_address <= pt_address_nx;
      ct_address <= ct_address_nx;
      ct_data    <= ct_data_nx;
      ct_wren    <= ct_wren_nx;
`ifdef RC4_DROP_EN
      dcnt       <= dcnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Directed bench for rc4_encrypt_core with behavioural S RAM, plaintext ROM and ciphertext RAM.
module tb_rc4_encrypt_core;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [23:0] secret_key;
  logic        busy, done, s_wren, ct_wren;
  logic [7:0]  s_address, s_data, s_q, pt_address, pt_q, ct_address, ct_data;

  logic [7:0]  s_mem  [256];
  logic [7:0]  pt_mem [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  exp_ct [32];
  logic [7:0]  s_addr_r, pt_addr_r;
  bit          ct_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ct_wr_cnt = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  rc4_encrypt_core #(.MSG_LEN(32), .KEY_LEN(3), .DROP_N(256)) dut (
    .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
    .busy(busy), .done(done),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .pt_address(pt_address), .pt_q(pt_q),
    .ct_address(ct_address), .ct_data(ct_data), .ct_wren(ct_wren)
  );

  // Registered-address memories: data for an address appears after the next edge.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_address] <= s_data;
    s_addr_r  <= s_address;
    pt_addr_r <= pt_address;
    if (ct_clr) begin
      for (int n = 0; n < 256; n++) ct_mem[n] <= 8'h00;
    end else if (ct_wren) begin
      ct_mem[ct_address] <= ct_data;
    end
  end
  assign s_q  = s_mem[s_addr_r];
  assign pt_q = pt_mem[pt_addr_r];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ct_wren) ct_wr_cnt++;
    if (s_wren && ct_wren) overlap_cnt++;
  end

  // Reference RC4 over the 32-byte plaintext image, 3-byte key.
  function automatic void rc4_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] ii, jj, tmp, t;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    jj = 8'h00;
    for (int n = 0; n < 256; n++) begin
      jj = jj + s[n] + key[8*(2-(n%3)) +: 8];
      tmp = s[n]; s[n] = s[jj]; s[jj] = tmp;
    end
    ii = 8'h00; jj = 8'h00;
    for (int n = 0; n < 32; n++) begin
      ii = ii + 8'd1;
      jj = jj + s[ii];
      tmp = s[ii]; s[ii] = s[jj]; s[jj] = tmp;
      t = s[ii] + s[jj];
      exp_ct[n] = s[t] ^ pt_mem[n];
    end
  endfunction

  task automatic clear_ct();
    @(negedge clk); ct_clr = 1'b1;
    @(negedge clk); ct_clr = 1'b0;
  endtask

  task automatic load_plaintext();
    logic [71:0] txt;
    txt = "Plaintext";
    for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
    for (int n = 0; n < 9; n++) pt_mem[n] = txt[8*(8-n) +: 8];
  endtask

  task automatic run_enc(input logic [23:0] key, output bit finished,
                         output logic busy1, output logic done2);
    int unsigned cyc;
    clear_ct();
    done_cnt = 0;
    ct_wr_cnt = 0;
    @(negedge clk); secret_key = key; start = 1'b1;
    @(negedge clk); start = 1'b0; busy1 = busy;
    cyc = 0;
    while (!done && cyc < 6000) begin @(negedge clk); cyc++; end
    finished = done;
    @(negedge clk); done2 = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; secret_key = 24'h0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({busy, done, s_wren, ct_wren} !== 4'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, s_wren, ct_wren});
    end
    n_cmp++;
    if ({s_address, s_data, pt_address, ct_address, ct_data} !== 40'h0) begin
      n_err++; $display("FAIL reset_bus: got %h want 0", {s_address, s_data, pt_address, ct_address, ct_data});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_vector();
    bit fin; logic b1, d2;
    logic [71:0] ref_ct;
    ref_ct = 72'hBBF316E8D940AF0AD3;
    load_plaintext();
    rc4_model(24'h4B6579);
    run_enc(24'h4B6579, fin, b1, d2);
    n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL kv_timeout: done got %b want 1", fin); end
    n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL kv_busy: got %b want 1", b1); end
    n_cmp++; if (d2 !== 1'b0) begin n_err++; $display("FAIL kv_done_width: got %b want 0", d2); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL kv_busy_end: got %b want 0", busy); end
    n_cmp++; if (ct_wr_cnt != 32) begin n_err++; $display("FAIL kv_ct_writes: got %0d want 32", ct_wr_cnt); end
    for (int n = 0; n < 9; n++) begin
      n_cmp++;
      if (ct_mem[n] !== ref_ct[8*(8-n) +: 8]) begin
        n_err++; $display("FAIL kv_ct[%0d]: got %h want %h", n, ct_mem[n], ref_ct[8*(8-n) +: 8]);
      end
    end
    for (int n = 9; n < 32; n++) begin
      n_cmp++;
      if (ct_mem[n] !== exp_ct[n]) begin
        n_err++; $display("FAIL kv_tail[%0d]: got %h want %h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_zero_plaintext();
    bit fin; logic b1, d2;
    logic [23:0] ks;
    ks = 24'hEB9F77;
    for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
    rc4_model(24'h4B6579);
    run_enc(24'h4B6579, fin, b1, d2);
    n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL zp_timeout: done got %b want 1", fin); end
    for (int n = 0; n < 3; n++) begin
      n_cmp++;
      if (ct_mem[n] !== ks[8*(2-n) +: 8]) begin
        n_err++; $display("FAIL zp_ks[%0d]: got %h want %h", n, ct_mem[n], ks[8*(2-n) +: 8]);
      end
    end
    for (int n = 0; n < 32; n++) begin
      n_cmp++;
      if (ct_mem[n] !== exp_ct[n]) begin
        n_err++; $display("FAIL zp_ct[%0d]: got %h want %h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_roundtrip();
    bit fin; logic b1, d2;
    logic [7:0] orig [32];
    load_plaintext();
    for (int n = 0; n < 32; n++) orig[n] = pt_mem[n];
    run_enc(24'h4B6579, fin, b1, d2);
    for (int n = 0; n < 32; n++) pt_mem[n] = ct_mem[n];
    run_enc(24'h4B6579, fin, b1, d2);
    n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL rt_timeout: done got %b want 1", fin); end
    for (int n = 0; n < 32; n++) begin
      n_cmp++;
      if (ct_mem[n] !== orig[n]) begin
        n_err++; $display("FAIL rt_pt[%0d]: got %h want %h", n, ct_mem[n], orig[n]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit fin; logic b1, d2;
    load_plaintext();
    rc4_model(24'h4B6579);
    clear_ct();
    @(negedge clk); secret_key = 24'h4B6579; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (256 + 700 + 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, s_wren, ct_wren} !== 4'b0) begin
      n_err++; $display("FAIL mr_ctrl: got %b want 0000", {busy, done, s_wren, ct_wren});
    end
    n_cmp++;
    if ({s_address, s_data, pt_address, ct_address, ct_data} !== 40'h0) begin
      n_err++; $display("FAIL mr_bus: got %h want 0", {s_address, s_data, pt_address, ct_address, ct_data});
    end
    reset = 1'b0;
    run_enc(24'h4B6579, fin, b1, d2);
    n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL mr_timeout: done got %b want 1", fin); end
    for (int n = 0; n < 32; n++) begin
      n_cmp++;
      if (ct_mem[n] !== exp_ct[n]) begin
        n_err++; $display("FAIL mr_ct[%0d]: got %h want %h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int unsigned cyc;
    load_plaintext();
    rc4_model(24'h4B6579);
    clear_ct();
    done_cnt = 0;
    @(negedge clk); secret_key = 24'h4B6579; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 6000) begin
      @(negedge clk); cyc++;
      if (cyc == 40 || cyc == 1200) begin secret_key = secret_key ^ 24'hA5A5A5; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL sb_done_count: got %0d want 1", done_cnt); end
    for (int n = 0; n < 32; n++) begin
      n_cmp++;
      if (ct_mem[n] !== exp_ct[n]) begin
        n_err++; $display("FAIL sb_ct[%0d]: got %h want %h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_zero_key();
    bit fin; logic b1, d2;
    for (int n = 0; n < 256; n++) pt_mem[n] = 8'(n * 7 + 3);
    rc4_model(24'h000000);
    run_enc(24'h000000, fin, b1, d2);
    n_cmp++; if (fin !== 1'b1) begin n_err++; $display("FAIL zk_timeout: done got %b want 1", fin); end
    for (int n = 0; n < 32; n++) begin
      n_cmp++;
      if (ct_mem[n] !== exp_ct[n]) begin
        n_err++; $display("FAIL zk_ct[%0d]: got %h want %h", n, ct_mem[n], exp_ct[n]);
      end
    end
    n_cmp++;
    if (overlap_cnt != 0) begin n_err++; $display("FAIL wren_overlap: got %0d cycles want 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_zero_plaintext();
    test_roundtrip();
    test_reset_mid_run();
    test_start_while_busy();
    test_zero_key();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
